// File: rtl/layer_input_buffer.sv
// Single-buffered activation collector: packs the upstream activation stream into
// words, then replays the stored vector one or more times as a packed word stream.
module layer_input_buffer #(
    parameter int BITWIDTH = 4,
    parameter int PACK     = 3,
    parameter int VEC_LEN  = 480
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic [BITWIDTH-1:0]      a_tdata,
    input  logic                     a_tvalid,
    output logic                     a_tready,
    output logic [BITWIDTH*PACK-1:0] x_tdata,
    output logic                     x_tvalid,
    input  logic                     x_tready,
    input  logic [3:0]               replays,
    output logic [1:0]               status
);
    localparam int WORDS = (VEC_LEN + PACK - 1) / PACK;
    localparam int WW    = BITWIDTH * PACK;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int SW    = (PACK > 1) ? $clog2(PACK) : 1;

    // LOAD is the first cycle of playback, used to fetch word 0 from memory
    typedef enum logic [1:0] {FILL, LOAD, PLAY} state_t;
    state_t state, next_state;

    logic [WW-1:0] mem [WORDS];
    logic [WW-1:0] acc, acc_merged, next_word;
    logic [CW-1:0] act_cnt;
    logic [SW-1:0] slot;
    logic [AW-1:0] wr_addr, la_ptr, out_ptr, rd_addr;
    logic [3:0]    pass_cnt, replays_q;
    logic          a_accept, a_last, word_done, x_accept, x_final, x_load;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(WORDS - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        a_accept   = a_tvalid && a_tready;
        a_last     = a_accept && (act_cnt == CW'(VEC_LEN - 1));
        word_done  = a_accept && ((slot == SW'(PACK - 1)) || a_last);
        x_accept   = x_tvalid && x_tready;
        x_final    = x_accept && (out_ptr == AW'(WORDS - 1))
                     && (({1'b0, pass_cnt} + 5'd1) >= {1'b0, replays_q});
        x_load     = (state == PLAY) && (!x_tvalid || x_tready) && !x_final;
        // next_word always holds the word at la_ptr, so it reads one further ahead on a load
        rd_addr    = x_load ? wrap_inc(la_ptr) : la_ptr;
        acc_merged = acc;
        acc_merged[slot*BITWIDTH +: BITWIDTH] = a_tdata;
        case (state)
            FILL:    if (a_last) next_state = LOAD;
            LOAD:    next_state = PLAY;
            PLAY:    if (x_final) next_state = FILL;
            default: next_state = FILL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (word_done) begin
            mem[wr_addr] <= acc_merged;
        end
        next_word <= mem[rd_addr];
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            a_tready  <= 1'b0;
            x_tvalid  <= 1'b0;
            x_tdata   <= '0;
            status    <= '0;
            acc       <= '0;
            act_cnt   <= '0;
            slot      <= '0;
            wr_addr   <= '0;
            la_ptr    <= '0;
            out_ptr   <= '0;
            pass_cnt  <= '0;
            replays_q <= 4'd1;
        end else begin
            a_tready  <= (next_state == FILL);
            status[0] <= (next_state != FILL);
            status[1] <= x_final;

            if (a_accept) begin
                act_cnt <= a_last ? '0 : act_cnt + 1'b1;
                if (word_done) begin
                    acc     <= '0;
                    slot    <= '0;
                    wr_addr <= a_last ? '0 : wr_addr + 1'b1;
                end else begin
                    acc  <= acc_merged;
                    slot <= slot + 1'b1;
                end
            end

            if (a_last) begin
                replays_q <= (replays == 4'd0) ? 4'd1 : replays;
                pass_cnt  <= '0;
                la_ptr    <= '0;
            end

            if (x_load) begin
                x_tdata  <= next_word;
                x_tvalid <= 1'b1;
                out_ptr  <= la_ptr;
                la_ptr   <= wrap_inc(la_ptr);
            end

            if (x_final) begin
                x_tvalid <= 1'b0;
            end else if (x_accept && (out_ptr == AW'(WORDS - 1))) begin
                pass_cnt <= pass_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_layer_input_buffer.sv
// Bench for layer_input_buffer: a short-vector instance driven from a record table
// and random records, plus a default-size instance for the full-length replay.
module tb_layer_input_buffer;
    localparam int VL     = 7;
    localparam int NW     = (VL + 2) / 3;
    localparam int XW     = NW * 12;
    localparam int BIG_VL = 480;
    localparam int BIG_NW = (BIG_VL + 2) / 3;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic [3:0]  a_tdata, replays;
    logic        a_tvalid, a_tready, x_tvalid, x_tready;
    logic [11:0] x_tdata;
    logic [1:0]  status;
    logic [3:0]  b_a_tdata, b_replays;
    logic        b_a_tvalid, b_a_tready, b_x_tvalid, b_x_tready;
    logic [11:0] b_x_tdata;
    logic [1:0]  b_status;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic [27:0] acts;
        logic [3:0]  rep;
        int          vmode;
        int          rmode;
        logic [XW-1:0] exp_words;
        int          exp_passes;
    } vec_t;

    vec_t vecs[$];

    always #5 CLK = ~CLK;

    layer_input_buffer #(.BITWIDTH(4), .PACK(3), .VEC_LEN(VL)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready),
        .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready),
        .replays(replays), .status(status)
    );

    layer_input_buffer dut_big (
        .CLK(CLK), .RSTN(RSTN),
        .a_tdata(b_a_tdata), .a_tvalid(b_a_tvalid), .a_tready(b_a_tready),
        .x_tdata(b_x_tdata), .x_tvalid(b_x_tvalid), .x_tready(b_x_tready),
        .replays(b_replays), .status(b_status)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference packing: activation i lands in word i/3, slot i%3; missing slots are zero
    function automatic logic [XW-1:0] packVector(input logic [27:0] acts);
        logic [XW-1:0] words;
        int w;
        int s;
        words = '0;
        for (int i = 0; i < VL; i++) begin
            w = i / 3;
            s = i % 3;
            words[w*12 + s*4 +: 4] = acts[i*4 +: 4];
        end
        return words;
    endfunction

    task automatic applyStimulus(input vec_t v, input string tag);
        logic [11:0] exp_q[$];
        logic [11:0] got_q[$];
        logic [11:0] prev_data;
        logic        prev_stall;
        int idx, cyc, k, first_valid, gaps, stall_err, ready_err, play_err, fill_err, pulses;
        bit done;

        for (int p = 0; p < v.exp_passes; p++) begin
            for (int w = 0; w < NW; w++) begin
                exp_q.push_back(v.exp_words[w*12 +: 12]);
            end
        end

        idx = 0; cyc = 0; fill_err = 0;
        replays = v.rep;
        while (idx < VL && cyc < 200) begin
            if (x_tvalid) fill_err++;
            case (v.vmode)
                0:       a_tvalid = 1'b1;
                1:       a_tvalid = (cyc % 2 == 0);
                default: a_tvalid = 1'($urandom_range(0, 1));
            endcase
            a_tdata  = a_tvalid ? v.acts[idx*4 +: 4] : 4'hA;
            x_tready = (v.rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (a_tvalid && a_tready) idx++;
            @(negedge CLK);
            cyc++;
        end
        checkOutput($sformatf("%s fill count", tag), idx, VL);
        checkOutput($sformatf("%s x_tvalid during fill", tag), fill_err, 0);

        k = 0; first_valid = -1; gaps = 0; stall_err = 0; ready_err = 0;
        play_err = 0; pulses = 0; done = 0; prev_stall = 1'b0; prev_data = '0;
        while (!done && k < 200) begin
            if (status[1]) pulses++;
            if (prev_stall && (!x_tvalid || x_tdata != prev_data)) stall_err++;
            if (x_tvalid && first_valid < 0) first_valid = k;
            if (first_valid >= 0 && !x_tvalid) gaps++;
            if (a_tready) ready_err++;
            if (!status[0]) play_err++;

            a_tvalid = (v.vmode == 2) ? 1'($urandom_range(0, 1)) : (v.vmode == 1);
            a_tdata  = 4'hA;
            case (v.rmode)
                0:       x_tready = 1'b1;
                1:       x_tready = (k % 2 == 0);
                default: x_tready = 1'($urandom_range(0, 1));
            endcase
            replays    = 4'($urandom_range(0, 15));
            prev_stall = x_tvalid && !x_tready;
            prev_data  = x_tdata;
            if (x_tvalid && x_tready) begin
                got_q.push_back(x_tdata);
                if (got_q.size() == exp_q.size()) done = 1;
            end
            @(negedge CLK);
            k++;
        end

        if (status[1]) pulses++;
        checkOutput($sformatf("%s x_tvalid after last beat", tag), x_tvalid, 0);
        checkOutput($sformatf("%s a_tready after last beat", tag), a_tready, 1);
        checkOutput($sformatf("%s playing after last beat", tag), status[0], 0);
        a_tvalid = 1'b0;
        x_tready = 1'b0;
        @(negedge CLK);
        if (status[1]) pulses++;

        checkOutput($sformatf("%s first valid latency", tag), first_valid, 2);
        checkOutput($sformatf("%s beat count", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checkOutput($sformatf("%s beat %0d", tag, i), got_q[i], exp_q[i]);
        end
        checkOutput($sformatf("%s gaps", tag), gaps, 0);
        checkOutput($sformatf("%s stall changes", tag), stall_err, 0);
        checkOutput($sformatf("%s a_tready during play", tag), ready_err, 0);
        checkOutput($sformatf("%s status0 low during play", tag), play_err, 0);
        checkOutput($sformatf("%s done pulses", tag), pulses, 1);
    endtask

    task automatic resetMidPlay();
        int idx;
        int cyc;
        idx = 0; cyc = 0;
        replays  = 4'd1;
        x_tready = 1'b1;
        while (idx < VL && cyc < 100) begin
            a_tvalid = 1'b1;
            a_tdata  = 4'(idx + 1);
            if (a_tready) idx++;
            @(negedge CLK);
            cyc++;
        end
        a_tvalid = 1'b0;
        while (!x_tvalid && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
        checkOutput("rst first beat", x_tdata, 12'h321);
        @(negedge CLK);
        RSTN = 1'b0;
        @(negedge CLK);
        checkOutput("rst x_tvalid", x_tvalid, 0);
        checkOutput("rst a_tready", a_tready, 0);
        checkOutput("rst status", status, 0);
        checkOutput("rst x_tdata", x_tdata, 0);
        RSTN = 1'b1;
        x_tready = 1'b0;
        @(negedge CLK);
        checkOutput("rst release a_tready", a_tready, 1);
    endtask

    task automatic runBig();
        int idx, cyc, first, beats, bad, gaps, pulses;
        idx = 0; cyc = 0;
        b_replays  = 4'd2;
        b_x_tready = 1'b1;
        while (idx < BIG_VL && cyc < 2000) begin
            b_a_tvalid = 1'b1;
            b_a_tdata  = 4'hF;
            if (b_a_tready) idx++;
            @(negedge CLK);
            cyc++;
        end
        b_a_tvalid = 1'b0;
        checkOutput("big fill count", idx, BIG_VL);
        first = -1; beats = 0; bad = 0; gaps = 0; pulses = 0;
        for (int k = 0; k < 2 * BIG_NW + 20; k++) begin
            if (b_status[1]) pulses++;
            if (b_x_tvalid) begin
                if (first < 0) first = k;
                beats++;
                if (b_x_tdata != 12'hFFF) bad++;
            end else if (first >= 0 && beats < 2 * BIG_NW) begin
                gaps++;
            end
            @(negedge CLK);
        end
        checkOutput("big latency", first, 2);
        checkOutput("big beats", beats, 2 * BIG_NW);
        checkOutput("big bad data", bad, 0);
        checkOutput("big gaps", gaps, 0);
        checkOutput("big pulses", pulses, 1);
        checkOutput("big a_tready after", b_a_tready, 1);
    endtask

    initial begin
        vec_t v;
        RSTN = 1'b0;
        a_tvalid = 1'b0; a_tdata = '0; x_tready = 1'b0; replays = 4'd1;
        b_a_tvalid = 1'b0; b_a_tdata = '0; b_x_tready = 1'b0; b_replays = 4'd1;

        vecs.push_back('{28'h7654321, 4'd1, 0, 0, 36'h007654321, 1});
        vecs.push_back('{28'h7654321, 4'd3, 0, 0, 36'h007654321, 3});
        vecs.push_back('{28'h7654321, 4'd0, 0, 0, 36'h007654321, 1});
        vecs.push_back('{28'h7654321, 4'd1, 0, 1, 36'h007654321, 1});
        vecs.push_back('{28'h7654321, 4'd1, 1, 0, 36'h007654321, 1});
        for (int i = 0; i < 6; i++) begin
            v.acts       = 28'($urandom);
            v.rep        = 4'($urandom_range(0, 4));
            v.vmode      = 2;
            v.rmode      = 2;
            v.exp_words  = packVector(v.acts);
            v.exp_passes = (v.rep == 4'd0) ? 1 : int'(v.rep);
            vecs.push_back(v);
        end

        repeat (3) @(negedge CLK);
        checkOutput("reset a_tready", a_tready, 0);
        checkOutput("reset x_tvalid", x_tvalid, 0);
        checkOutput("reset x_tdata", x_tdata, 0);
        checkOutput("reset status", status, 0);
        checkOutput("reset big a_tready", b_a_tready, 0);
        RSTN = 1'b1;
        @(negedge CLK);
        checkOutput("release a_tready", a_tready, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        resetMidPlay();
        applyStimulus('{28'h1234567, 4'd1, 0, 0, 36'h001234567, 1}, "refill");

        runBig();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
